// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the boot-time instruction ROM loader.
// Loader state encodings, core reset polarity and bus widths live here.
package inst_rom_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 32;

  // Polarity of the reset driven into the OpenMIPS core.
  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  localparam logic [WORD_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_LOAD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERR    = 3'd4
  } ld_state_e;

  // True when a header word count does not fit in a 2**dlog2-word array.
  function automatic logic cnt_too_big(input logic [CNT_W-1:0] n,
                                       input int unsigned      dlog2);
    logic [WORD_W:0] depth;
    depth = (WORD_W+1)'(1) << dlog2;
    return (WORD_W+1)'(n) > depth;
  endfunction

endpackage

// File: rtl/inst_rom_loader_ld_word_asm.sv
// Packs loader bytes MSB-first into 32-bit words; flags the 4th byte of each word.
// Word and valid are combinational so the write lands on the accepting edge.
module ld_word_asm
  import inst_rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_c_o,
  output logic              word_valid_c_o
);

  logic [1:0]  byte_sel_q;
  logic [23:0] sr_q;

  // Only the first three bytes are stored; the fourth is taken straight from the input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_sel_q <= 2'd0;
      sr_q       <= 24'd0;
    end else if (clr_i) begin
      byte_sel_q <= 2'd0;
    end else if (shift_i) begin
      sr_q       <= {sr_q[15:0], byte_i};
      byte_sel_q <= byte_sel_q + 2'd1;
    end
  end

  assign word_c_o       = {sr_q, byte_i};
  assign word_valid_c_o = shift_i && (byte_sel_q == 2'd3);

endmodule

// File: rtl/inst_rom_loader.sv
// Boot instruction memory for OpenMIPS: loads a length-prefixed byte stream,
// serves combinational fetches and holds the core in reset until loading completes.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid_i,
  input  logic [BYTE_W-1:0] ld_data_i,
  output logic              ld_ready_o,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [WORD_W-1:0] rom_data_o,
  output logic              core_rst_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [CNT_W-1:0]  word_cnt_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned IDX_W = DEPTH_LOG2;

  ld_state_e               state_q;
  logic [BYTE_W-1:0]       hdr_hi_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        wr_idx_q;
  logic                    ld_ready_q;
  logic                    core_rst_q;
  logic                    load_done_q;
  logic                    load_err_q;

  logic                    accept;
  logic [CNT_W-1:0]        hdr_n;
  logic                    asm_clr;
  logic                    asm_shift;
  logic [WORD_W-1:0]       asm_word;
  logic                    asm_word_valid;
  logic                    mem_we;

  logic [WORD_W-1:0]       mem [DEPTH];

  assign accept    = ld_valid_i && ld_ready_q;
  assign hdr_n     = {hdr_hi_q, ld_data_i};
  assign asm_clr   = (state_q == ST_HDR_LO) && accept;
  assign asm_shift = (state_q == ST_LOAD) && accept;
  assign mem_we    = rst && (state_q == ST_LOAD) && asm_word_valid;

  ld_word_asm u_word_asm (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (asm_clr),
    .shift_i        (asm_shift),
    .byte_i         (ld_data_i),
    .word_c_o       (asm_word),
    .word_valid_c_o (asm_word_valid)
  );

  // Loader FSM; outputs are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_HDR_HI;
      hdr_hi_q    <= '0;
      cnt_q       <= '0;
      wr_idx_q    <= '0;
      ld_ready_q  <= 1'b1;
      core_rst_q  <= RST_ENABLE;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_HDR_HI: begin
          if (accept) begin
            hdr_hi_q <= ld_data_i;
            state_q  <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (accept) begin
            cnt_q    <= hdr_n;
            wr_idx_q <= '0;
            if (hdr_n == '0) begin
              state_q     <= ST_RUN;
              ld_ready_q  <= 1'b0;
              core_rst_q  <= RST_DISABLE;
              load_done_q <= 1'b1;
            end else if (cnt_too_big(hdr_n, DEPTH_LOG2)) begin
              state_q    <= ST_ERR;
              ld_ready_q <= 1'b0;
              load_err_q <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (asm_word_valid) begin
            wr_idx_q <= wr_idx_q + IDX_W'(1);
            if (wr_idx_q == IDX_W'(cnt_q - CNT_W'(1))) begin
              state_q     <= ST_RUN;
              ld_ready_q  <= 1'b0;
              core_rst_q  <= RST_DISABLE;
              load_done_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Single write port; contents survive reset and are hidden by the word count.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx_q] <= asm_word;
    end
  end

  logic [IDX_W-1:0]             rd_idx;
  logic [ADDR_W-IDX_W-3:0]      rd_hi;
  logic                         rd_hit;
  logic [1:0]                   unused_byte_off;

  assign rd_idx          = rom_addr_i[DEPTH_LOG2+1:2];
  assign rd_hi           = rom_addr_i[ADDR_W-1:DEPTH_LOG2+2];
  assign unused_byte_off = rom_addr_i[1:0];
  assign rd_hit          = rom_ce_i && (rd_hi == '0) &&
                           ((CNT_W+1)'(rd_idx) < (CNT_W+1)'(cnt_q));

  // Asynchronous read; misses return a NOP.
  assign rom_data_o  = rd_hit ? mem[rd_idx] : ZERO_WORD;

  assign ld_ready_o  = ld_ready_q;
  assign core_rst_o  = core_rst_q;
  assign load_done_o = load_done_q;
  assign load_err_o  = load_err_q;
  assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader against a stream-level reference model.
module tb_inst_rom_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid_i;
  logic [7:0]  ld_data_i;
  logic        ld_ready_o;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        core_rst_o;
  logic        load_done_o;
  logic        load_err_o;
  logic [15:0] word_cnt_o;

  int n_checks = 0;
  int n_err    = 0;

  // Bytes the model says the DUT has accepted since the last reset.
  logic [7:0] acc_q[$];

  always #5 clk = ~clk;

  inst_rom_loader #(.DEPTH_LOG2(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid_i  (ld_valid_i),
    .ld_data_i   (ld_data_i),
    .ld_ready_o  (ld_ready_o),
    .rom_ce_i    (rom_ce_i),
    .rom_addr_i  (rom_addr_i),
    .rom_data_o  (rom_data_o),
    .core_rst_o  (core_rst_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o),
    .word_cnt_o  (word_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_n();
    if (acc_q.size() < 2) return 0;
    return int'({acc_q[0], acc_q[1]});
  endfunction

  function automatic bit exp_err();
    return (acc_q.size() >= 2) && (exp_n() > 1024);
  endfunction

  function automatic bit exp_run();
    return (acc_q.size() >= 2) && !exp_err() && (acc_q.size() >= 2 + 4 * exp_n());
  endfunction

  function automatic bit exp_ready();
    return !exp_run() && !exp_err();
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    return {acc_q[2+4*i], acc_q[3+4*i], acc_q[4+4*i], acc_q[5+4*i]};
  endfunction

  function automatic logic [31:0] exp_read(input logic ce, input logic [31:0] addr);
    int idx;
    if (!ce || addr >= 32'h1000) return 32'h0;
    idx = int'(addr >> 2);
    if (idx >= exp_n()) return 32'h0;
    return exp_word(idx);
  endfunction

  function automatic bq_t make_stream(input int n);
    bq_t s;
    logic [15:0] nn;
    nn = 16'(n);
    s.push_back(nn[15:8]);
    s.push_back(nn[7:0]);
    if (n <= 1024) begin
      for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
    end
    return s;
  endfunction

  task automatic check_state();
    chk("core_rst",  32'(core_rst_o),  32'(!exp_run()));
    chk("load_done", 32'(load_done_o), 32'(exp_run()));
    chk("load_err",  32'(load_err_o),  32'(exp_err()));
    chk("ld_ready",  32'(ld_ready_o),  32'(exp_ready()));
    chk("word_cnt",  32'(word_cnt_o),  32'(exp_n()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    ld_valid_i = 1'b1;
    ld_data_i  = 8'h55;
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0;
    @(negedge clk);
    acc_q.delete();
    chk("rst_core_rst",  32'(core_rst_o),  32'd1);
    chk("rst_load_done", 32'(load_done_o), 32'd0);
    chk("rst_load_err",  32'(load_err_o),  32'd0);
    chk("rst_rom_data",  rom_data_o,       32'h0);
    chk("rst_word_cnt",  32'(word_cnt_o),  32'd0);
    rst        = 1'b1;
    ld_valid_i = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every 3rd cycle, 2: random gaps.
  task automatic feed(input bq_t s, input int mode);
    int  i;
    int  cyc;
    bit  v;
    i   = 0;
    cyc = 0;
    while (i < s.size()) begin
      @(negedge clk);
      check_state();
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 2);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      ld_valid_i = v;
      ld_data_i  = v ? s[i] : 8'($urandom);
      if (v) begin
        if (exp_ready()) acc_q.push_back(s[i]);
        i++;
      end
      cyc++;
      if (cyc > 30000) begin
        chk("feed_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(negedge clk);
    ld_valid_i = 1'b0;
    check_state();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_state();
    end
  endtask

  task automatic rd(input logic ce, input logic [31:0] addr, input logic [31:0] exp,
                    input string tag);
    @(negedge clk);
    rom_ce_i   = ce;
    rom_addr_i = addr;
    #1;
    chk(tag, rom_data_o, exp);
  endtask

  task automatic rand_reads(input int k);
    for (int j = 0; j < k; j++) begin
      int          kind;
      logic [31:0] a;
      logic        ce;
      kind = int'($urandom_range(0, 3));
      ce   = 1'b1;
      case (kind)
        0:       a = (exp_n() > 0) ? (32'($urandom_range(0, exp_n() - 1)) << 2) : 32'h0;
        1:       a = 32'(exp_n() + int'($urandom_range(0, 3))) << 2;
        2:       a = 32'h1000 + ($urandom & 32'h0FFF_FFFF);
        default: begin
          ce = 1'b0;
          a  = 32'($urandom_range(0, 4095));
        end
      endcase
      a[1:0] = 2'($urandom);
      rd(ce, a, exp_read(ce, a), "rand_rd");
    end
  endtask

  initial begin
    bq_t s1;
    bq_t s;
    rst        = 1'b0;
    ld_valid_i = 1'b0;
    ld_data_i  = 8'h00;
    rom_ce_i   = 1'b0;
    rom_addr_i = 32'h0;
    s1 = {8'h00, 8'h02, 8'h3C, 8'h01, 8'h01, 8'h01, 8'h34, 8'h21, 8'h00, 8'h20};

    // Two-word program, back-to-back.
    do_reset();
    feed(s1, 0);
    rd(1'b1, 32'h0,    32'h3C01_0101, "s1_w0");
    rd(1'b1, 32'h4,    32'h3421_0020, "s1_w1");
    rd(1'b1, 32'h8,    32'h0,         "s1_past_end");
    rd(1'b1, 32'h3,    32'h3C01_0101, "s1_addr3");
    rd(1'b0, 32'h0,    32'h0,         "s1_ce_low");
    rd(1'b1, 32'h1000, 32'h0,         "s1_above_array");
    chk("s1_word_cnt", 32'(word_cnt_o), 32'd2);

    // Empty program.
    do_reset();
    s = {8'h00, 8'h00};
    feed(s, 0);
    chk("s2_core_rst", 32'(core_rst_o), 32'd0);
    rd(1'b1, 32'h0, 32'h0, "s2_rd0");
    rand_reads(6);

    // Oversized header, followed by bytes that must be refused.
    do_reset();
    s = {8'h04, 8'h01, 8'h11, 8'h22, 8'h33};
    feed(s, 0);
    idle(20);
    chk("s3_load_err", 32'(load_err_o), 32'd1);
    chk("s3_core_rst", 32'(core_rst_o), 32'd1);
    rd(1'b0, 32'h0, 32'h0, "s3_ce_low");

    // Sparse valid, then extra bytes in RUN.
    do_reset();
    feed(s1, 1);
    s = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    feed(s, 1);
    rd(1'b1, 32'h0, 32'h3C01_0101, "s4_w0");
    rd(1'b1, 32'h4, 32'h3421_0020, "s4_w1");
    rd(1'b1, 32'h8, 32'h0,         "s4_past_end");

    // Reset after five accepted bytes, then a one-word program.
    do_reset();
    s = {};
    for (int i = 0; i < 5; i++) s.push_back(s1[i]);
    feed(s, 0);
    do_reset();
    s = {8'h00, 8'h01, 8'h24, 8'h02, 8'h00, 8'h05};
    feed(s, 0);
    rd(1'b1, 32'h0, 32'h2402_0005, "s5_w0");
    rd(1'b1, 32'h4, 32'h0,         "s5_old_hidden");

    // Random programs, including the full-depth boundary and one past it.
    for (int it = 0; it < 8; it++) begin
      int n;
      if (it == 6)      n = 1024;
      else if (it == 7) n = 1025;
      else              n = int'($urandom_range(1, 24));
      do_reset();
      feed(make_stream(n), it % 3);
      idle(2);
      if (n <= 1024) begin
        rand_reads(12);
        if (n == 1024) begin
          rd(1'b1, 32'hFFC,  exp_word(1023), "full_last");
          rd(1'b1, 32'h1000, 32'h0,          "full_above");
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Boot-time instruction memory for the OpenMIPS core. Receives a program as a byte stream over a valid/ready loader port, packs bytes into big-endian 32-bit words and writes them into an internal word array. Serves the core's instruction-fetch port with a combinational read. Holds the core in reset until the whole program has been loaded.

## Interface
- `DEPTH_LOG2`, 10: log2 of instruction memory depth in 32-bit words (1024 words).
- `Inst_Addr` / `Reg` widths come from `define.v` (32).

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset; one clock.
- `ld_valid_i`  in  1  loader byte valid.
- `ld_data_i`  in  8  loader byte.
- `ld_ready_o`  out  1  loader byte accepted when `ld_valid_i && ld_ready_o` at the rising edge.
- `rom_ce_i`  in  1  fetch enable from core (`rom_ce_o`).
- `rom_addr_i`  in  32  byte address from core (`rom_addr_o`).
- `rom_data_o`  out  32  instruction to core (`rom_data_i`), combinational.
- `core_rst_o`  out  1  active-high reset for OpenMIPS; registered.
- `load_done_o`  out  1  program loaded, core running.
- `load_err_o`  out  1  header word count exceeded depth.
- `word_cnt_o`  out  16  loaded program length in words.

## Operation
- Stream format: 16-bit word count N, MSB first. Then N words, 4 bytes each, MSB first (first byte → bits 31:24).
- States:
  - HDR_HI: `ld_ready_o`=1. On accept, cnt[15:8] ← byte → HDR_LO.
  - HDR_LO: `ld_ready_o`=1. On accept, cnt[7:0] ← byte.
    - If full N = 0 → RUN.
    - If N > 2^DEPTH_LOG2 → ERR.
    - Otherwise → LOAD, with wr_idx = 0 and byte_sel = 0.
  - LOAD: `ld_ready_o`=1. Each accept shifts the byte into the word shift register and increments byte_sel (2 bits, wraps 3→0).
    - On the accept with byte_sel = 3, mem[wr_idx] ← assembled word and wr_idx increments.
    - If that write was for wr_idx = N−1 → RUN.
  - RUN: `ld_ready_o`=0; extra bytes are never accepted. Terminal until reset.
  - ERR: `ld_ready_o`=0, `load_err_o`=1, `core_rst_o` stays 1. Terminal until reset.
- Read path:
  - Word index = `rom_addr_i[DEPTH_LOG2+1:2]`; `rom_addr_i[1:0]` is ignored.
  - `rom_data_o` = mem[index] when `rom_ce_i`=1 and word index of `rom_addr_i` < N.
  - Otherwise `rom_data_o` = 0 (a NOP). This covers `rom_ce_i`=0, addresses past the program, and any address above the array.
  - Memory is not cleared on reset. Stale contents are unreachable because N is reset to 0.
- `core_rst_o` = 1 in every state except RUN. `load_done_o` = (state == RUN). `word_cnt_o` = N.

## Timing
- Reset values: state HDR_HI, N=0, wr_idx=0, byte_sel=0.
- Output values during reset: `core_rst_o`=1, `load_done_o`=0, `load_err_o`=0, `ld_ready_o`=1 in the cycle after reset releases, `rom_data_o`=0.
- Reset mid-load: any state returns to HDR_HI on the next edge. A partially assembled word is discarded.
- Word write: occurs on the edge that accepts the 4th byte. The word is readable on `rom_data_o` from the next cycle.
- RUN entry: state enters RUN on the final write edge. `core_rst_o` falls and `load_done_o` rises in the cycle after that edge (registered outputs).
- Read latency: zero cycles (combinational from `rom_addr_i`/`rom_ce_i`), matching the core's fetch expectation.
- Throughput: one byte per cycle. `ld_valid_i` gaps stall progress without losing state.
- Simultaneous events: reset low takes priority over a byte accept in the same cycle.

## Structure
- Put these in `define.v` as `define`s:
  - state encodings (3 bits: HDR_HI, HDR_LO, LOAD, RUN, ERR);
  - `Rst_Enable` polarity for `core_rst_o`;
  - the ZERO word constant.
- Sub-module `ld_word_asm`: the byte shift register plus byte_sel counter, with a `word_valid` pulse output. This keeps the FSM and the memory array in `inst_rom_loader`.
- The memory array is inferred as distributed RAM: one synchronous write port, one asynchronous read port.

## Test plan
- Load bytes 00 02 3C 01 01 01 34 21 00 20 back-to-back.
  - Expect `core_rst_o` 1→0 one cycle after the last accept, `word_cnt_o`=2.
  - Reads: addr 0x0 → 0x3C010101, 0x4 → 0x34210020, 0x8 → 0x00000000.
- Load header 00 00.
  - Expect RUN after 2 accepts, `core_rst_o`=0, and every read returns 0.
- Load header 04 01 (N=1025 > 1024).
  - Expect `load_err_o`=1, `ld_ready_o`=0, and `core_rst_o` held at 1 indefinitely.
- Repeat the first scenario with `ld_valid_i` asserted every 3rd cycle, then push 4 extra bytes in RUN.
  - Expect identical memory contents and `ld_ready_o`=0 for the extra bytes.
- Assert `rst` low after 5 accepted bytes, then load 00 01 24 02 00 05.
  - Expect addr 0x0 → 0x24020005 and addr 0x4 → 0 (the old word is hidden).
- In RUN, drive `rom_ce_i`=0 with addr 0x0.
  - Expect `rom_data_o`=0.
  - Addr 0x3 with `rom_ce_i`=1 returns the same word as 0x0.
